// File: rtl/otter_uart_tx_if.sv
// -----------------------------------------------------------------------------
// otter_uart_tx_if
// IO-bus bundle between the OTTER MCU and the UART transmitter.
//   addr    : MCU IO address (word address of the register being accessed)
//   wdata   : MCU IO write data
//   wr      : one-cycle write strobe
//   rd_data : combinational read data returned to the MCU IO input mux
// The MCU side uses the master modport, the UART uses the slave modport.
// -----------------------------------------------------------------------------
interface otter_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic [31:0] rd_data;

  modport master (output addr, output wdata, output wr, input rd_data);
  modport slave  (input addr, input wdata, input wr, output rd_data);
endinterface

// File: rtl/otter_uart_tx.sv
// -----------------------------------------------------------------------------
// otter_uart_tx
// Memory-mapped 8N1 UART transmitter on the OTTER IO bus. Byte writes to
// TXDATA are queued in a small circular FIFO and shifted out LSB first.
// STATUS (TXDATA+4) reports full/empty/busy/overflow and the FIFO occupancy.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : IO bus slave (addr, wdata, wr in; rd_data out)
//   tx_o    : registered serial output, idles high
//   busy_o  : high while a frame is in flight or bytes are still queued
// STATUS layout: [0] full, [1] empty, [2] fsm busy, [3] overflow (sticky,
// cleared by writing STATUS with bit 3 set), [11:8] count, others zero.
// -----------------------------------------------------------------------------
module otter_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0040
) (
  input  logic           clk,
  input  logic           rst_n,
  otter_uart_tx_if.slave bus,
  output logic           tx_o,
  output logic           busy_o
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              ovf_q;
  logic              ovf_d;

  logic fifo_empty;
  logic fifo_full;
  logic baud_done;
  logic pop;
  logic push_req;
  logic push_ok;
  logic clr_ovf;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_CNT);
  assign baud_done  = (baud_q == BAUD_LAST);

  // The FSM takes the head byte either straight from IDLE or at the last
  // stop-bit cycle, which is what makes back-to-back frames gapless.
  assign pop      = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_done));
  assign push_req = bus.wr && (bus.addr == BASE_ADDR);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push_ok  = push_req && (!fifo_full || pop);
  assign clr_ovf  = bus.wr && (bus.addr == STATUS_ADDR) && bus.wdata[3];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end else if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  // Storage array carries no reset; stale slots are never visible because
  // count and pointers are reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.wdata[7:0];
    end
  end

  // Pointers wrap for free because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Transmit FSM. Each bit is held for CLKS_PER_BIT cycles; the TX value for
  // the next bit is registered on the edge that leaves the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            state_q <= START;
            shift_q <= mem_q[rd_ptr_q];
            baud_q  <= '0;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            state_q <= DATA;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (pop) begin
              state_q <= START;
              shift_q <= mem_q[rd_ptr_q];
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  logic [3:0]  count_field;
  logic [31:0] status;
  logic        unused_wdata;

  assign count_field  = 4'(count_q);
  assign status       = {20'd0, count_field, 4'd0, ovf_q, (state_q != IDLE), fifo_empty, fifo_full};
  assign unused_wdata = ^bus.wdata[31:8];

  assign bus.rd_data = (bus.addr == STATUS_ADDR) ? status : 32'd0;
  assign tx_o        = tx_q;
  assign busy_o      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_otter_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_otter_uart_tx
// Self-checking bench for otter_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// A serial monitor decodes every frame on TX and compares it against a
// scoreboard queue filled when TXDATA writes are issued.
// -----------------------------------------------------------------------------
module tb_otter_uart_tx;

  localparam int          CLKS = 4;
  localparam logic [31:0] BASE = 32'h1100_0040;
  localparam logic [31:0] STAT = 32'h1100_0044;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rdAddr;
    logic [31:0] expRd;
    logic        expBusy;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic txO;
  logic busyO;

  int         vecCount  = 0;
  int         missCount = 0;
  int         cycleCnt  = 0;
  bit         monEnable = 1'b1;
  logic [7:0] sbQ [$];
  logic [7:0] monGot;
  logic [7:0] monExp;

  otter_uart_tx_if bus ();

  otter_uart_tx #(
    .CLKS_PER_BIT(CLKS),
    .FIFO_DEPTH(8),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .tx_o(txO),
    .busy_o(busyO)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Edge counter used to schedule writes on exact edges.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Write lands on the rising edge following the next falling edge.
  task automatic writeBus(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.addr  = addr;
    bus.wdata = data;
    bus.wr    = 1'b1;
    @(posedge clk);
    #1;
    bus.wr   = 1'b0;
    bus.addr = 32'h0;
  endtask

  task automatic readStatus(input string name, input logic [31:0] exp);
    bus.addr = STAT;
    #1;
    checkOutput(name, bus.rd_data, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.addr  = v.addr;
    bus.wdata = v.wdata;
    bus.wr    = v.wr;
    @(posedge clk);
    #1;
    bus.wr   = 1'b0;
    bus.addr = v.rdAddr;
    @(negedge clk);
    checkOutput({v.name, "_rd"}, bus.rd_data, v.expRd);
    checkOutput({v.name, "_busy"}, 32'(busyO), 32'(v.expBusy));
    checkOutput({v.name, "_tx"}, 32'(txO), 32'd1);
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (busyO !== 1'b0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", 32'(busyO), 32'd0);
  endtask

  // Expected TX level in cycle c (1-based) of a frame carrying d.
  function automatic logic expTx(input logic [7:0] d, input int c);
    int k;
    k = (c - 1) / CLKS;
    if (k == 0) return 1'b0;
    else if (k <= 8) return d[k-1];
    else return 1'b1;
  endfunction

  // Serial monitor: on the first low TX cycle, sample each data bit at its
  // first cycle, check the stop bit, then compare against the scoreboard.
  always begin
    @(negedge clk);
    if (monEnable && rst_n && txO === 1'b0) begin
      for (int b = 0; b < 8; b++) begin
        repeat (CLKS) @(negedge clk);
        monGot[b] = txO;
      end
      repeat (CLKS) @(negedge clk);
      checkOutput("stop_bit", 32'(txO), 32'd1);
      if (sbQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL rx_unexpected: got byte 0x%02h, expected no frame", monGot);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("rx_byte", 32'(monGot), 32'(monExp));
      end
    end
  end

  initial begin
    vec_t vecs [6];
    logic [7:0] d0;
    logic [7:0] d1;
    int edgeN;

    vecs[0] = '{"rd_status",     STAT,          32'h0,         1'b0, STAT,          32'h2, 1'b0};
    vecs[1] = '{"rd_txdata",     BASE,          32'h0,         1'b0, BASE,          32'h0, 1'b0};
    vecs[2] = '{"rd_other",      32'h1100_0048, 32'h0,         1'b0, 32'h1100_0048, 32'h0, 1'b0};
    vecs[3] = '{"wr_status_all", STAT,          32'hFFFF_FFFF, 1'b1, STAT,          32'h2, 1'b0};
    vecs[4] = '{"wr_other",      32'h1100_0048, 32'h0000_00AB, 1'b1, STAT,          32'h2, 1'b0};
    vecs[5] = '{"wr_below",      32'h1100_003C, 32'h0000_0012, 1'b1, STAT,          32'h2, 1'b0};

    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    bus.wr    = 1'b0;

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", 32'(txO), 32'd1);
    checkOutput("rst_busy", 32'(busyO), 32'd0);
    readStatus("rst_status", 32'h2);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] address decode vectors");
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    $display("[TB] single frame 0xA5");
    d0 = 8'hA5;
    sbQ.push_back(d0);
    writeBus(BASE, 32'hFFFF_FFA5);
    @(negedge clk);
    checkOutput("a5_latency_tx", 32'(txO), 32'd1);
    for (int c = 1; c <= 10 * CLKS; c++) begin
      @(negedge clk);
      checkOutput($sformatf("a5_tx_c%0d", c), 32'(txO), 32'(expTx(d0, c)));
      checkOutput($sformatf("a5_busy_c%0d", c), 32'(busyO), 32'd1);
    end
    @(negedge clk);
    checkOutput("a5_busy_end", 32'(busyO), 32'd0);
    checkOutput("a5_tx_end", 32'(txO), 32'd1);
    waitIdle(100);

    $display("[TB] back-to-back frames 0x55, 0xF0");
    d0 = 8'h55;
    d1 = 8'hF0;
    sbQ.push_back(d0);
    sbQ.push_back(d1);
    writeBus(BASE, 32'(d0));
    writeBus(BASE, 32'(d1));
    for (int c = 1; c <= 20 * CLKS; c++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_tx_c%0d", c), 32'(txO),
                  32'((c <= 10 * CLKS) ? expTx(d0, c) : expTx(d1, c - 10 * CLKS)));
    end
    @(negedge clk);
    checkOutput("b2b_busy_end", 32'(busyO), 32'd0);
    checkOutput("b2b_tx_end", 32'(txO), 32'd1);
    waitIdle(100);

    $display("[TB] overflow, status clear, full-FIFO push on pop edge");
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sbQ.push_back(8'(i));
      writeBus(BASE, 32'(i));
      if (i == 0) edgeN = cycleCnt;
    end
    @(negedge clk);
    readStatus("ovf_status", 32'h0000_080D);
    writeBus(STAT, 32'h0000_0007);
    @(negedge clk);
    readStatus("ovf_keep", 32'h0000_080D);
    writeBus(STAT, 32'h0000_0008);
    @(negedge clk);
    readStatus("ovf_clear", 32'h0000_0805);
    writeBus(32'h1100_0048, 32'h0000_0077);
    @(negedge clk);
    readStatus("bad_addr_nopush", 32'h0000_0805);
    while (cycleCnt < edgeN + 39) @(negedge clk);
    sbQ.push_back(8'h0A);
    writeBus(BASE, 32'h0000_000A);
    @(negedge clk);
    readStatus("push_on_pop", 32'h0000_0805);
    waitIdle(1000);
    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
    readStatus("idle_status", 32'h2);

    $display("[TB] reset mid-frame");
    monEnable = 1'b0;
    writeBus(BASE, 32'h0000_003C);
    writeBus(BASE, 32'h0000_0011);
    repeat (8) @(negedge clk);
    checkOutput("mid_tx_low", 32'(txO), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_tx", 32'(txO), 32'd1);
    checkOutput("mid_rst_busy", 32'(busyO), 32'd0);
    readStatus("mid_rst_status", 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    readStatus("post_rst_status", 32'h2);
    checkOutput("post_rst_tx", 32'(txO), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
